act_skew_feeder: RTL and testbench

Left-edge activation feeder for the weight-stationary systolic array. It buffers incoming activation vectors (one element per array row) behind a valid/ready handshake, then drives them into the array's row inputs with a diagonal skew: row r is delayed r cycles, so partial sums meet the right activations as they move down each column. It also separates tiles with a drain phase and flags when the last element of a tile has entered the array.

---
 rtl/osiris_sa_pkg.sv | 13 +
 rtl/vec_fifo.sv | 47 ++++
 rtl/act_skew_feeder.sv | 158 +++++++++++++++
 tb/tb_act_skew_feeder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/osiris_sa_pkg.sv
// Shared types and constants for the systolic-array feeder blocks.
package osiris_sa_pkg;

  localparam int unsigned DefaultDw  = 16;
  localparam int unsigned BubbleCntW = 16;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StDrain
  } feeder_state_e;

endpackage

// File: rtl/vec_fifo.sv
// Synchronous vector FIFO with flush; a full FIFO refuses pushes even when popping.
module vec_fifo #(
  parameter int unsigned Width = 65,
  parameter int unsigned Depth = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW:0]      wptr_q, rptr_q;
  logic             push_ok, pop_ok;

  // Extra pointer MSB distinguishes full from empty.
  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign push_ok = push && !full && !clr;
  assign pop_ok  = pop && !empty && !clr;
  assign rdata   = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (clr) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + (AW+1)'(1);
      if (pop_ok)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/act_skew_feeder.sv
// Skewed activation feeder for the array's left edge.
// Optional stall-bubble counter enabled by ACT_FEEDER_BUBBLE_CNT_EN.
module act_skew_feeder
  import osiris_sa_pkg::*;
#(
  parameter int unsigned DW    = DefaultDw,
  parameter int unsigned ROWS  = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [ROWS*DW-1:0]    s_data,
  input  logic                  s_last,
  output logic [ROWS*DW-1:0]    a_row,
  output logic [ROWS-1:0]       a_valid_row,
  output logic                  busy,
  output logic                  drain_done,
  output logic [BubbleCntW-1:0] bubble_cnt
);

  localparam int unsigned VW = ROWS * DW;
  localparam int unsigned CW = $clog2(ROWS + 1);

  feeder_state_e state_q, state_d;
  logic [CW-1:0] drain_cnt_q, drain_cnt_d;
  logic          full, empty, pop, head_last;
  logic [VW:0]   head;
  logic [VW-1:0] head_data;

  vec_fifo #(
    .Width(VW + 1),
    .Depth(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .push (s_valid),
    .wdata({s_last, s_data}),
    .pop  (pop),
    .rdata(head),
    .full (full),
    .empty(empty)
  );

  assign s_ready   = !full;
  assign head_last = head[VW];
  assign head_data = head[VW-1:0];
  assign busy      = (state_q != StIdle) || !empty;

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    pop         = 1'b0;
    case (state_q)
      StIdle: begin
        drain_cnt_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          state_d = head_last ? StDrain : StStream;
        end
      end
      StStream: begin
        drain_cnt_d = '0;
        if (!empty) begin
          pop = 1'b1;
          if (head_last) state_d = StDrain;
        end
      end
      StDrain: begin
        // ROWS-1 drain cycles; a single-row array leaves after one.
        if (32'(drain_cnt_q) + 32'd2 >= ROWS) state_d = StIdle;
        else drain_cnt_d = drain_cnt_q + CW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      drain_cnt_q <= '0;
    end else if (clr) begin
      state_q     <= StIdle;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Row r: stage-0 register plus r+1 further registers to its output.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [DW-1:0] d_q [r+2];
    logic          v_q [r+2];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < r + 2; k++) begin
          d_q[k] <= '0;
          v_q[k] <= 1'b0;
        end
      end else if (clr) begin
        for (int k = 0; k < r + 2; k++) begin
          d_q[k] <= '0;
          v_q[k] <= 1'b0;
        end
      end else begin
        d_q[0] <= pop ? head_data[r*DW +: DW] : '0;
        v_q[0] <= pop;
        for (int k = 1; k < r + 2; k++) begin
          d_q[k] <= d_q[k-1];
          v_q[k] <= v_q[k-1];
        end
      end
    end

    assign a_row[r*DW +: DW] = d_q[r+1];
    assign a_valid_row[r]    = v_q[r+1];
  end

  // Tile-last marker travels alongside the last row.
  logic last_q [ROWS+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < ROWS + 1; k++) last_q[k] <= 1'b0;
    end else if (clr) begin
      for (int k = 0; k < ROWS + 1; k++) last_q[k] <= 1'b0;
    end else begin
      last_q[0] <= pop && head_last;
      for (int k = 1; k < ROWS + 1; k++) last_q[k] <= last_q[k-1];
    end
  end

  assign drain_done = last_q[ROWS];

`ifdef ACT_FEEDER_BUBBLE_CNT_EN
  logic [BubbleCntW-1:0] bubble_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_q <= '0;
    end else if (clr) begin
      bubble_q <= '0;
    end else if ((state_q == StStream) && empty && (bubble_q != '1)) begin
      bubble_q <= bubble_q + BubbleCntW'(1);
    end
  end

  assign bubble_cnt = bubble_q;
`else
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_act_skew_feeder.sv
// Directed self-checking bench for act_skew_feeder (ROWS=4, DW=16, DEPTH=8).
module tb_act_skew_feeder;

  localparam int unsigned DW    = 16;
  localparam int unsigned ROWS  = 4;
  localparam int unsigned DEPTH = 8;

  logic                 clk, rst_n, clr, s_valid, s_ready, s_last;
  logic [ROWS*DW-1:0]   s_data, a_row;
  logic [ROWS-1:0]      a_valid_row;
  logic                 busy, drain_done;
  logic [15:0]          bubble_cnt;

  int n_total = 0;
  int n_pass  = 0;

  act_skew_feeder #(
    .DW   (DW),
    .ROWS (ROWS),
    .DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .a_row      (a_row),
    .a_valid_row(a_valid_row),
    .busy       (busy),
    .drain_done (drain_done),
    .bubble_cnt (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row-0 capture for the FIFO-full scenario.
  logic        collect = 1'b0;
  logic [15:0] got_q[$];
  always @(negedge clk) if (collect && a_valid_row[0]) got_q.push_back(a_row[15:0]);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] vec(input int base);
    return {16'(base + 3), 16'(base + 2), 16'(base + 1), 16'(base)};
  endfunction

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 64'(busy), 64'd0);
    repeat (6) tick();
  endtask

  // One vector {4,3,2,1} with s_last, accepted at edge 0.
  task automatic run_single(input string tag);
    s_valid = 1'b1;
    s_data  = 64'h0004_0003_0002_0001;
    s_last  = 1'b1;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk({tag, "_v_e0"}, 64'(a_valid_row), 64'd0);
    tick();
    chk({tag, "_v_e1"}, 64'(a_valid_row), 64'd0);
    for (int r = 0; r < 4; r++) begin
      tick();
      chk($sformatf("%s_v_e%0d", tag, r + 2), 64'(a_valid_row), 64'(4'b0001 << r));
      chk($sformatf("%s_d_e%0d", tag, r + 2), 64'(a_row[r*16 +: 16]), 64'(r + 1));
      chk($sformatf("%s_dd_e%0d", tag, r + 2), 64'(drain_done), 64'(r == 3));
    end
    tick();
    chk({tag, "_dd_after"}, 64'(drain_done), 64'd0);
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    chk({tag, "_v_after"}, 64'(a_valid_row), 64'd0);
  endtask

  logic [3:0]  vh [16];
  logic [15:0] ah [16];
  logic        dd [16];
  int          cnt;

  initial begin
    rst_n   = 1'b0;
    clr     = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    #12;
    chk("rst_a_row", 64'(a_row), 64'd0);
    chk("rst_valid", 64'(a_valid_row), 64'd0);
    chk("rst_dd", 64'(drain_done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_bubble", 64'(bubble_cnt), 64'd0);
    chk("rst_ready", 64'(s_ready), 64'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // Single vector skew and drain pulse.
    run_single("single");

    // FIFO fill: single-vector tiles pop only once every 4 cycles.
    collect = 1'b1;
    s_valid = 1'b1;
    s_last  = 1'b1;
    for (int i = 0; i < 11; i++) begin
      s_data = vec(100 + i);
      tick();
    end
    chk("full_e10", 64'(s_ready), 64'd0);
    s_data = vec(111);
    tick();
    chk("full_e11", 64'(s_ready), 64'd0);
    tick();
    chk("full_e12", 64'(s_ready), 64'd0);
    tick();
    chk("freed_e13", 64'(s_ready), 64'd1);
    tick();
    chk("refull_e14", 64'(s_ready), 64'd0);
    s_valid = 1'b0;
    s_last  = 1'b0;
    wait_idle("full_idle");
    collect = 1'b0;
    chk("full_count", 64'(got_q.size()), 64'd12);
    for (int i = 0; i < 12 && i < got_q.size(); i++)
      chk($sformatf("full_order%0d", i), 64'(got_q[i]), 64'(100 + i));

    // Three-vector tile with a two-cycle input gap.
    for (int e = 0; e < 13; e++) begin
      s_valid = (e == 0) || (e == 1) || (e == 4);
      s_last  = (e == 4);
      s_data  = vec(16 * (e + 1));
      tick();
      vh[e] = a_valid_row;
      ah[e] = a_row[15:0];
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    for (int r = 0; r < 4; r++) begin
      chk($sformatf("bub_on_r%0d_a", r), 64'(vh[2+r][r]), 64'd1);
      chk($sformatf("bub_on_r%0d_b", r), 64'(vh[3+r][r]), 64'd1);
      chk($sformatf("bub_gap_r%0d_a", r), 64'(vh[4+r][r]), 64'd0);
      chk($sformatf("bub_gap_r%0d_b", r), 64'(vh[5+r][r]), 64'd0);
      chk($sformatf("bub_on_r%0d_c", r), 64'(vh[6+r][r]), 64'd1);
    end
    chk("bub_d0", 64'(ah[2]), 64'd16);
    chk("bub_d1", 64'(ah[3]), 64'd32);
    chk("bub_zero_a", 64'(ah[4]), 64'd0);
    chk("bub_zero_b", 64'(ah[5]), 64'd0);
    chk("bub_d2", 64'(ah[6]), 64'd80);
`ifdef ACT_FEEDER_BUBBLE_CNT_EN
    chk("bubble_cnt", 64'(bubble_cnt), 64'd2);
`else
    chk("bubble_cnt", 64'(bubble_cnt), 64'd0);
`endif
    wait_idle("bub_idle");

    // Two back-to-back tiles: last on vectors 2 and 4.
    for (int e = 0; e < 15; e++) begin
      s_valid = (e < 4);
      s_last  = (e == 1) || (e == 3);
      s_data  = vec(e + 1);
      tick();
      vh[e] = a_valid_row;
      dd[e] = drain_done;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    cnt = 0;
    for (int e = 0; e < 15; e++) if (dd[e]) cnt++;
    chk("tiles_dd_count", 64'(cnt), 64'd2);
    chk("tiles_dd_first", 64'(dd[6]), 64'd1);
    chk("tiles_dd_second", 64'(dd[11]), 64'd1);
    cnt = 0;
    for (int e = 4; e < 7; e++) if (!vh[e][0]) cnt++;
    chk("tiles_gap3", 64'(cnt), 64'd3);
    chk("tiles_t1_end", 64'(vh[3][0]), 64'd1);
    chk("tiles_t2_start", 64'(vh[7][0]), 64'd1);
    wait_idle("tiles_idle");

    // Flush mid-stream with a simultaneous push.
    s_valid = 1'b1;
    s_last  = 1'b0;
    s_data  = vec(200);
    tick();
    s_data = vec(300);
    tick();
    clr    = 1'b1;
    s_data = vec(400);
    tick();
    clr     = 1'b0;
    s_valid = 1'b0;
    chk("clr_valid", 64'(a_valid_row), 64'd0);
    chk("clr_busy", 64'(busy), 64'd0);
    chk("clr_ready", 64'(s_ready), 64'd1);
    cnt = 0;
    for (int e = 0; e < 8; e++) begin
      if (a_valid_row != 0 || drain_done) cnt++;
      tick();
    end
    chk("clr_quiet", 64'(cnt), 64'd0);

    // Asynchronous reset while in drain.
    s_valid = 1'b1;
    s_last  = 1'b1;
    s_data  = vec(500);
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(a_valid_row), 64'd0);
    chk("arst_row", 64'(a_row), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_dd", 64'(drain_done), 64'd0);
    chk("arst_bubble", 64'(bubble_cnt), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_ready", 64'(s_ready), 64'd1);
    run_single("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
